// File: rtl/tmds_rx_decoder.sv
// Receive-side TMDS period tracker and decoder for one HDMI link (three aligned channels).
// Two register stages: aligned symbols in, decoded period/data out.
module tmds_rx_decoder #(
  parameter int PREAMBLE_LEN = 8
) (
  input  logic        clk_pixel,
  input  logic        reset,
  input  logic [9:0]  tmds0,
  input  logic [9:0]  tmds1,
  input  logic [9:0]  tmds2,
  output logic [2:0]  mode,
  output logic [23:0] video_data,
  output logic [11:0] data_island_data,
  output logic [5:0]  control_data,
  output logic [4:0]  island_index,
  output logic        preamble_short,
  output logic [2:0]  symbol_error
);

  localparam logic [2:0] ST_CONTROL = 3'd0;
  localparam logic [2:0] ST_VIDEO   = 3'd1;
  localparam logic [2:0] ST_VGUARD  = 3'd2;
  localparam logic [2:0] ST_ISLAND  = 3'd3;
  localparam logic [2:0] ST_DLEAD   = 3'd4;
  localparam logic [2:0] ST_DTRAIL  = 3'd5;

  localparam logic [9:0] GUARD_A   = 10'b1011001100;
  localparam logic [9:0] GUARD_B   = 10'b0100110011;
  localparam logic [3:0] PRE_MAX   = 4'(PREAMBLE_LEN);
  localparam logic [1:0] GUARD_LAST = 2'd1;

  // {valid, bits[1:0]}
  function automatic logic [2:0] ctrl_dec(input logic [9:0] s);
    case (s)
      10'b1101010100: ctrl_dec = 3'b100;
      10'b0010101011: ctrl_dec = 3'b101;
      10'b0101010100: ctrl_dec = 3'b110;
      10'b1010101011: ctrl_dec = 3'b111;
      default:        ctrl_dec = 3'b000;
    endcase
  endfunction

  // {valid, nibble[3:0]}
  function automatic logic [4:0] terc_dec(input logic [9:0] s);
    case (s)
      10'b1010011100: terc_dec = 5'h10;
      10'b1001100011: terc_dec = 5'h11;
      10'b1011100100: terc_dec = 5'h12;
      10'b1011100010: terc_dec = 5'h13;
      10'b0101110001: terc_dec = 5'h14;
      10'b0100011110: terc_dec = 5'h15;
      10'b0110001110: terc_dec = 5'h16;
      10'b0100111100: terc_dec = 5'h17;
      10'b1011001100: terc_dec = 5'h18;
      10'b0100111001: terc_dec = 5'h19;
      10'b0110011100: terc_dec = 5'h1A;
      10'b1011000110: terc_dec = 5'h1B;
      10'b1010001110: terc_dec = 5'h1C;
      10'b1001110001: terc_dec = 5'h1D;
      10'b0101100011: terc_dec = 5'h1E;
      10'b1011000011: terc_dec = 5'h1F;
      default:        terc_dec = 5'h00;
    endcase
  endfunction

  function automatic logic [7:0] video_dec(input logic [9:0] s);
    logic [7:0] q;
    logic [7:0] d;
    q = s[9] ? ~s[7:0] : s[7:0];
    d[0] = q[0];
    for (int i = 1; i < 8; i++) begin
      d[i] = s[8] ? (q[i] ^ q[i-1]) : ~(q[i] ^ q[i-1]);
    end
    return d;
  endfunction

  logic        s1_valid_q, s1_valid_d;
  logic [9:0]  sym0_q, sym0_d, sym1_q, sym1_d, sym2_q, sym2_d;
  logic [2:0]  state_q, state_d;
  logic [1:0]  guard_cnt_q, guard_cnt_d;
  logic [3:0]  pre_cnt_q, pre_cnt_d;
  logic        pre_island_q, pre_island_d;
  logic [4:0]  isl_cnt_q, isl_cnt_d;
  logic [2:0]  mode_q, mode_d;
  logic [23:0] video_data_q, video_data_d;
  logic [11:0] data_island_data_q, data_island_data_d;
  logic [5:0]  control_data_q, control_data_d;
  logic [4:0]  island_index_q, island_index_d;
  logic        preamble_short_q, preamble_short_d;
  logic [2:0]  symbol_error_q, symbol_error_d;

  logic [2:0] c0, c1, c2;
  logic [4:0] t0, t1, t2;
  logic       vid_guard, isl_pair, isl_ch0_ok, all_ctrl, pre_video, pre_island, ctrl_like;

  always_comb begin
    c0 = ctrl_dec(sym0_q);
    c1 = ctrl_dec(sym1_q);
    c2 = ctrl_dec(sym2_q);
    t0 = terc_dec(sym0_q);
    t1 = terc_dec(sym1_q);
    t2 = terc_dec(sym2_q);
    vid_guard  = (sym0_q == GUARD_A) && (sym1_q == GUARD_B) && (sym2_q == GUARD_A);
    isl_pair   = (sym1_q == GUARD_B) && (sym2_q == GUARD_B);
    isl_ch0_ok = t0[4] && (t0[3:2] == 2'b11);
    all_ctrl   = c0[2] && c1[2] && c2[2];
    pre_video  = all_ctrl && (c1[1:0] == 2'b01) && (c2[1:0] == 2'b00);
    pre_island = all_ctrl && (c1[1:0] == 2'b01) && (c2[1:0] == 2'b01);
    // A trailing island guard that ends is processed exactly like a control character.
    ctrl_like  = (state_q == ST_CONTROL) || ((state_q == ST_DTRAIL) && !isl_pair);
  end

  always_comb begin
    s1_valid_d         = 1'b1;
    sym0_d             = tmds0;
    sym1_d             = tmds1;
    sym2_d             = tmds2;
    state_d            = state_q;
    guard_cnt_d        = guard_cnt_q;
    pre_cnt_d          = pre_cnt_q;
    pre_island_d       = pre_island_q;
    isl_cnt_d          = isl_cnt_q;
    mode_d             = mode_q;
    video_data_d       = video_data_q;
    data_island_data_d = data_island_data_q;
    control_data_d     = control_data_q;
    island_index_d     = island_index_q;
    preamble_short_d   = 1'b0;
    symbol_error_d     = 3'b000;

    if (s1_valid_q) begin
      if (ctrl_like) begin
        island_index_d = 5'd0;
        guard_cnt_d    = 2'd1;
        if (vid_guard) begin
          state_d          = ST_VGUARD;
          mode_d           = 3'd2;
          preamble_short_d = (pre_cnt_q < PRE_MAX) || pre_island_q;
          pre_cnt_d        = 4'd0;
        end else if (isl_pair && isl_ch0_ok) begin
          state_d             = ST_DLEAD;
          mode_d              = 3'd4;
          preamble_short_d    = (pre_cnt_q < PRE_MAX) || !pre_island_q;
          pre_cnt_d           = 4'd0;
          control_data_d[1:0] = t0[1:0];
        end else begin
          state_d = ST_CONTROL;
          mode_d  = 3'd0;
          if (c0[2]) control_data_d[1:0] = c0[1:0];
          if (c1[2]) control_data_d[3:2] = c1[1:0];
          if (c2[2]) control_data_d[5:4] = c2[1:0];
          symbol_error_d = {!c2[2], !c1[2], !c0[2]};
          // Run length only continues while the same preamble type repeats.
          if (pre_video || pre_island) begin
            if ((pre_cnt_q != 4'd0) && (pre_island_q == pre_island)) begin
              pre_cnt_d = (pre_cnt_q >= PRE_MAX) ? pre_cnt_q : pre_cnt_q + 4'd1;
            end else begin
              pre_cnt_d    = 4'd1;
              pre_island_d = pre_island;
            end
          end else begin
            pre_cnt_d = 4'd0;
          end
        end
      end else begin
        pre_cnt_d = 4'd0;
        case (state_q)
          ST_VGUARD: begin
            mode_d         = 3'd2;
            island_index_d = 5'd0;
            symbol_error_d = {sym2_q != GUARD_A, sym1_q != GUARD_B, sym0_q != GUARD_A};
            if (guard_cnt_q >= GUARD_LAST) begin
              state_d     = ST_VIDEO;
              guard_cnt_d = 2'd0;
            end else begin
              guard_cnt_d = guard_cnt_q + 2'd1;
            end
          end
          ST_DLEAD: begin
            mode_d         = 3'd4;
            island_index_d = 5'd0;
            symbol_error_d = {sym2_q != GUARD_B, sym1_q != GUARD_B, !isl_ch0_ok};
            if (isl_ch0_ok) control_data_d[1:0] = t0[1:0];
            if (guard_cnt_q >= GUARD_LAST) begin
              state_d     = ST_ISLAND;
              guard_cnt_d = 2'd0;
              isl_cnt_d   = 5'd0;
            end else begin
              guard_cnt_d = guard_cnt_q + 2'd1;
            end
          end
          ST_ISLAND, ST_DTRAIL: begin
            if (isl_pair) begin
              state_d        = ST_DTRAIL;
              mode_d         = 3'd4;
              symbol_error_d = {1'b0, 1'b0, !isl_ch0_ok};
              if (isl_ch0_ok) control_data_d[1:0] = t0[1:0];
            end else begin
              mode_d         = 3'd3;
              island_index_d = isl_cnt_q;
              isl_cnt_d      = isl_cnt_q + 5'd1;
              if (t0[4]) data_island_data_d[3:0]  = t0[3:0];
              if (t1[4]) data_island_data_d[7:4]  = t1[3:0];
              if (t2[4]) data_island_data_d[11:8] = t2[3:0];
              if (t0[4]) control_data_d[1:0] = t0[1:0];
              symbol_error_d = {!t2[4], !t1[4], !t0[4]};
            end
          end
          ST_VIDEO: begin
            island_index_d = 5'd0;
            if (all_ctrl) begin
              state_d        = ST_CONTROL;
              mode_d         = 3'd0;
              control_data_d = {c2[1:0], c1[1:0], c0[1:0]};
            end else begin
              mode_d         = 3'd1;
              video_data_d   = {video_dec(sym2_q), video_dec(sym1_q), video_dec(sym0_q)};
              symbol_error_d = {c2[2], c1[2], c0[2]};
            end
          end
          default: state_d = ST_CONTROL;
        endcase
      end
    end
  end

  always_ff @(posedge clk_pixel or posedge reset) begin
    if (reset) begin
      s1_valid_q         <= 1'b0;
      sym0_q             <= '0;
      sym1_q             <= '0;
      sym2_q             <= '0;
      state_q            <= ST_CONTROL;
      guard_cnt_q        <= '0;
      pre_cnt_q          <= '0;
      pre_island_q       <= 1'b0;
      isl_cnt_q          <= '0;
      mode_q             <= '0;
      video_data_q       <= '0;
      data_island_data_q <= '0;
      control_data_q     <= '0;
      island_index_q     <= '0;
      preamble_short_q   <= 1'b0;
      symbol_error_q     <= '0;
    end else begin
      s1_valid_q         <= s1_valid_d;
      sym0_q             <= sym0_d;
      sym1_q             <= sym1_d;
      sym2_q             <= sym2_d;
      state_q            <= state_d;
      guard_cnt_q        <= guard_cnt_d;
      pre_cnt_q          <= pre_cnt_d;
      pre_island_q       <= pre_island_d;
      isl_cnt_q          <= isl_cnt_d;
      mode_q             <= mode_d;
      video_data_q       <= video_data_d;
      data_island_data_q <= data_island_data_d;
      control_data_q     <= control_data_d;
      island_index_q     <= island_index_d;
      preamble_short_q   <= preamble_short_d;
      symbol_error_q     <= symbol_error_d;
    end
  end

  assign mode             = mode_q;
  assign video_data       = video_data_q;
  assign data_island_data = data_island_data_q;
  assign control_data     = control_data_q;
  assign island_index     = island_index_q;
  assign preamble_short   = preamble_short_q;
  assign symbol_error     = symbol_error_q;

endmodule

// File: tb/tb_tmds_rx_decoder.sv
// Self-checking bench for tmds_rx_decoder: per-cycle comparison against a behavioural
// period model, plus hand-computed literal checks on the directed sequences.
module tb_tmds_rx_decoder;

  localparam int PLEN = 8;

  localparam logic [9:0] CTL00 = 10'b1101010100;
  localparam logic [9:0] CTL01 = 10'b0010101011;
  localparam logic [9:0] GD    = 10'b0100110011;
  localparam logic [9:0] VG    = 10'b1011001100;
  localparam logic [9:0] T0000 = 10'b1010011100;
  localparam logic [9:0] T1010 = 10'b0110011100;
  localparam logic [9:0] T1100 = 10'b1010001110;
  localparam logic [9:0] BAD   = 10'b0000011111;

  localparam int PH_CTRL = 0, PH_VIDEO = 1, PH_VG = 2, PH_ISL = 3, PH_LEAD = 4, PH_TRAIL = 5;

  logic        clk_pixel = 1'b0;
  logic        reset = 1'b1;
  logic [9:0]  tmds0 = CTL00, tmds1 = CTL00, tmds2 = CTL00;
  logic [2:0]  mode;
  logic [23:0] video_data;
  logic [11:0] data_island_data;
  logic [5:0]  control_data;
  logic [4:0]  island_index;
  logic        preamble_short;
  logic [2:0]  symbol_error;

  int tests = 0;
  int fails = 0;

  logic [9:0] ctrl_tab [4]  = '{10'b1101010100, 10'b0010101011, 10'b0101010100, 10'b1010101011};
  logic [9:0] terc_tab [16] = '{10'b1010011100, 10'b1001100011, 10'b1011100100, 10'b1011100010,
                                10'b0101110001, 10'b0100011110, 10'b0110001110, 10'b0100111100,
                                10'b1011001100, 10'b0100111001, 10'b0110011100, 10'b1011000110,
                                10'b1010001110, 10'b1001110001, 10'b0101100011, 10'b1011000011};

  // Model state and the outputs it predicts for the most recently consumed character.
  int ph, pre_run, pre_kind, isl_pos, guard_seen;
  logic [2:0]  e_mode;
  logic [23:0] e_video;
  logic [11:0] e_island;
  logic [5:0]  e_ctrl;
  logic [4:0]  e_idx;
  logic        e_short;
  logic [2:0]  e_err;

  tmds_rx_decoder #(.PREAMBLE_LEN(PLEN)) dut (
    .clk_pixel(clk_pixel), .reset(reset),
    .tmds0(tmds0), .tmds1(tmds1), .tmds2(tmds2),
    .mode(mode), .video_data(video_data), .data_island_data(data_island_data),
    .control_data(control_data), .island_index(island_index),
    .preamble_short(preamble_short), .symbol_error(symbol_error)
  );

  always #5 clk_pixel = ~clk_pixel;

  function automatic int ctrl_code(input logic [9:0] s);
    for (int i = 0; i < 4; i++) if (ctrl_tab[i] == s) return i;
    return -1;
  endfunction

  function automatic int terc_code(input logic [9:0] s);
    for (int i = 0; i < 16; i++) if (terc_tab[i] == s) return i;
    return -1;
  endfunction

  function automatic logic [7:0] video_byte(input logic [9:0] s);
    logic [7:0] q;
    logic [7:0] d;
    q = s[9] ? ~s[7:0] : s[7:0];
    d[0] = q[0];
    for (int i = 1; i < 8; i++) d[i] = s[8] ? (q[i] ^ q[i-1]) : !(q[i] ^ q[i-1]);
    return d;
  endfunction

  task automatic model_reset();
    ph = PH_CTRL; pre_run = 0; pre_kind = 0; isl_pos = 0; guard_seen = 0;
    e_mode = '0; e_video = '0; e_island = '0; e_ctrl = '0; e_idx = '0; e_short = 1'b0; e_err = '0;
  endtask

  task automatic model_step(input logic [9:0] s0, input logic [9:0] s1, input logic [9:0] s2);
    logic [9:0] s [3];
    int cv [3];
    int tv [3];
    bit vg, ig, ig0;
    int k;
    s[0] = s0; s[1] = s1; s[2] = s2;
    for (int i = 0; i < 3; i++) begin
      cv[i] = ctrl_code(s[i]);
      tv[i] = terc_code(s[i]);
    end
    vg  = (s0 == VG) && (s1 == GD) && (s2 == VG);
    ig  = (s1 == GD) && (s2 == GD);
    ig0 = (tv[0] >= 12);
    e_short = 1'b0;
    e_err   = 3'b000;
    if (ph == PH_CTRL || (ph == PH_TRAIL && !ig)) begin
      e_idx = 5'd0;
      if (vg) begin
        e_mode = 3'd2; e_short = (pre_run < PLEN) || (pre_kind != 1);
        pre_run = 0; ph = PH_VG; guard_seen = 1;
      end else if (ig && ig0) begin
        e_mode = 3'd4; e_short = (pre_run < PLEN) || (pre_kind != 2);
        e_ctrl[1:0] = 2'(tv[0]);
        pre_run = 0; ph = PH_LEAD; guard_seen = 1;
      end else begin
        e_mode = 3'd0; ph = PH_CTRL;
        for (int i = 0; i < 3; i++) begin
          if (cv[i] >= 0) e_ctrl[2*i +: 2] = 2'(cv[i]);
          else e_err[i] = 1'b1;
        end
        if (cv[0] >= 0 && cv[1] == 1 && (cv[2] == 0 || cv[2] == 1)) begin
          k = (cv[2] == 0) ? 1 : 2;
          if (pre_run > 0 && k == pre_kind) pre_run = (pre_run + 1 > PLEN) ? PLEN : pre_run + 1;
          else begin pre_run = 1; pre_kind = k; end
        end else begin
          pre_run = 0;
        end
      end
    end else begin
      pre_run = 0;
      case (ph)
        PH_VG: begin
          e_mode = 3'd2; e_idx = 5'd0;
          e_err = {s2 != VG, s1 != GD, s0 != VG};
          guard_seen++;
          if (guard_seen >= 2) ph = PH_VIDEO;
        end
        PH_LEAD: begin
          e_mode = 3'd4; e_idx = 5'd0;
          e_err = {s2 != GD, s1 != GD, !ig0};
          if (ig0) e_ctrl[1:0] = 2'(tv[0]);
          guard_seen++;
          if (guard_seen >= 2) begin ph = PH_ISL; isl_pos = 0; end
        end
        PH_ISL, PH_TRAIL: begin
          if (ig) begin
            e_mode = 3'd4; ph = PH_TRAIL;
            e_err[0] = !ig0;
            if (ig0) e_ctrl[1:0] = 2'(tv[0]);
          end else begin
            e_mode = 3'd3; e_idx = 5'(isl_pos); isl_pos = (isl_pos + 1) % 32;
            for (int i = 0; i < 3; i++) begin
              if (tv[i] >= 0) e_island[4*i +: 4] = 4'(tv[i]);
              else e_err[i] = 1'b1;
            end
            if (tv[0] >= 0) e_ctrl[1:0] = 2'(tv[0]);
          end
        end
        default: begin
          e_idx = 5'd0;
          if (cv[0] >= 0 && cv[1] >= 0 && cv[2] >= 0) begin
            e_mode = 3'd0; ph = PH_CTRL;
            e_ctrl = {2'(cv[2]), 2'(cv[1]), 2'(cv[0])};
          end else begin
            e_mode = 3'd1;
            e_video = {video_byte(s2), video_byte(s1), video_byte(s0)};
            for (int i = 0; i < 3; i++) e_err[i] = (cv[i] >= 0);
          end
        end
      endcase
    end
  endtask

  // Each posedge: compare the outputs for the previous character, then feed the model the
  // character being captured on this edge.
  initial begin
    logic [9:0] cap0, cap1, cap2;
    model_reset();
    forever begin
      @(posedge clk_pixel);
      cap0 = tmds0; cap1 = tmds1; cap2 = tmds2;
      #1;
      if (reset) model_reset();
      tests++;
      if (mode !== e_mode || video_data !== e_video || data_island_data !== e_island ||
          control_data !== e_ctrl || island_index !== e_idx || preamble_short !== e_short ||
          symbol_error !== e_err) begin
        fails++;
        $display("[TB] FAIL model t=%0t got mode=%0d vid=%h isl=%h ctl=%h idx=%0d short=%b err=%b required mode=%0d vid=%h isl=%h ctl=%h idx=%0d short=%b err=%b",
                 $time, mode, video_data, data_island_data, control_data, island_index, preamble_short, symbol_error,
                 e_mode, e_video, e_island, e_ctrl, e_idx, e_short, e_err);
      end
      if (!reset) model_step(cap0, cap1, cap2);
    end
  end

  task automatic applyStimulus(input logic [9:0] a0, input logic [9:0] a1, input logic [9:0] a2);
    @(negedge clk_pixel);
    tmds0 = a0; tmds1 = a1; tmds2 = a2;
  endtask

  // Outputs read right after an applyStimulus reflect the character applied two calls earlier.
  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] required);
    tests++;
    if (actual !== required) begin
      fails++;
      $display("[TB] FAIL %s: got %0h required %0h", name, actual, required);
    end
  endtask

  task automatic island_entry();
    for (int i = 0; i < 8; i++) applyStimulus(CTL00, CTL01, CTL01);
    applyStimulus(T1100, GD, GD);
    applyStimulus(T1100, GD, GD);
  endtask

  initial begin
    logic [9:0] ch2;
    int j;
    repeat (3) @(negedge clk_pixel);
    checkOutput("reset_mode", 32'(mode), 0);
    checkOutput("reset_all", {1'b0, video_data, island_index, preamble_short, symbol_error} | 32'(data_island_data) | 32'(control_data), 0);
    reset = 1'b0;
    repeat (4) applyStimulus(CTL00, CTL00, CTL00);

    // Full-length video preamble, two guards, two video characters, then control.
    for (int i = 0; i < 10; i++) applyStimulus(CTL00, CTL01, CTL00);
    applyStimulus(VG, GD, VG);
    applyStimulus(VG, GD, VG);
    checkOutput("pre_mode", 32'(mode), 0);
    checkOutput("pre_ctrl", 32'(control_data), 32'h04);
    applyStimulus(10'b0100000000, 10'b0100000000, 10'b0100000000);
    checkOutput("vg1_mode", 32'(mode), 2);
    checkOutput("vg1_short", 32'(preamble_short), 0);
    applyStimulus(10'b1000000000, 10'b1000000000, 10'b1000000000);
    checkOutput("vg2_mode", 32'(mode), 2);
    applyStimulus(CTL00, CTL00, CTL00);
    checkOutput("vid0_mode", 32'(mode), 1);
    checkOutput("vid0_data", 32'(video_data), 32'h000000);
    applyStimulus(CTL00, CTL00, CTL00);
    checkOutput("vid1_data", 32'(video_data), 32'hFFFFFF);
    applyStimulus(CTL00, CTL00, CTL00);
    checkOutput("vid_end_mode", 32'(mode), 0);
    checkOutput("vid_end_ctrl", 32'(control_data), 0);
    applyStimulus(CTL00, CTL00, CTL00);

    // Short preamble; third guard-looking character is video.
    for (int i = 0; i < 3; i++) applyStimulus(CTL00, CTL01, CTL00);
    applyStimulus(VG, GD, VG);
    applyStimulus(VG, GD, VG);
    applyStimulus(VG, GD, VG);
    checkOutput("short_g1_mode", 32'(mode), 2);
    checkOutput("short_g1_pulse", 32'(preamble_short), 1);
    applyStimulus(10'b1000000000, 10'b1000000000, 10'b1000000000);
    checkOutput("short_g2_pulse", 32'(preamble_short), 0);
    applyStimulus(CTL00, CTL00, CTL00);
    checkOutput("guardlike_mode", 32'(mode), 1);
    checkOutput("guardlike_data", 32'(video_data), 32'hAB55AB);
    applyStimulus(CTL00, CTL00, CTL00);
    checkOutput("short_vid_data", 32'(video_data), 32'hFFFFFF);
    applyStimulus(CTL00, CTL00, CTL00);

    // Data island: 38 characters, with a TERC4 1010 then an illegal symbol on ch2.
    island_entry();
    for (int k = 0; k < 38; k++) begin
      ch2 = (k == 33) ? T1010 : (k == 34) ? BAD : T0000;
      applyStimulus(T0000, T0000, ch2);
      if (k == 0) begin
        checkOutput("lead1_mode", 32'(mode), 4);
        checkOutput("lead1_short", 32'(preamble_short), 0);
      end else if (k == 1) begin
        checkOutput("lead2_mode", 32'(mode), 4);
        checkOutput("lead2_idx", 32'(island_index), 0);
      end else begin
        j = k - 2;
        checkOutput("isl_mode", 32'(mode), 3);
        checkOutput("isl_idx", 32'(island_index), 32'(j % 32));
        if (j <= 32) checkOutput("isl_data", 32'(data_island_data), 0);
        if (j == 33) checkOutput("isl_nib_a", 32'(data_island_data), 32'hA00);
        if (j == 34) begin
          checkOutput("isl_err", 32'(symbol_error), 32'b100);
          checkOutput("isl_hold", 32'(data_island_data), 32'hA00);
        end
        if (j == 35) checkOutput("isl_err_clear", 32'(symbol_error), 0);
        if (j == 2) checkOutput("isl_ctrl", 32'(control_data[1:0]), 0);
      end
    end
    applyStimulus(T1100, GD, GD);
    applyStimulus(T1100, GD, GD);
    applyStimulus(CTL00, CTL00, CTL00);
    checkOutput("trail_mode", 32'(mode), 4);
    checkOutput("trail_idx", 32'(island_index), 5);
    applyStimulus(CTL00, CTL00, CTL00);
    applyStimulus(CTL00, CTL00, CTL00);
    checkOutput("post_isl_mode", 32'(mode), 0);

    // Reset in the middle of an island, then a video sequence after release.
    island_entry();
    for (int k = 0; k < 20; k++) applyStimulus(T0000, T0000, T0000);
    checkOutput("pre_rst_idx", 32'(island_index), 17);
    @(negedge clk_pixel);
    reset = 1'b1;
    tmds0 = CTL00; tmds1 = CTL00; tmds2 = CTL00;
    #1;
    checkOutput("rst_mode", 32'(mode), 0);
    checkOutput("rst_idx", 32'(island_index), 0);
    checkOutput("rst_data", 32'(data_island_data), 0);
    repeat (2) @(negedge clk_pixel);
    reset = 1'b0;
    for (int i = 0; i < 8; i++) applyStimulus(CTL00, CTL01, CTL00);
    applyStimulus(VG, GD, VG);
    applyStimulus(VG, GD, VG);
    applyStimulus(10'b1100001111, 10'b0001010101, 10'b0101010101);
    checkOutput("rr_g1_short", 32'(preamble_short), 0);
    applyStimulus(CTL00, 10'b0100000000, 10'b1000000000);
    checkOutput("rr_g2_mode", 32'(mode), 2);
    applyStimulus(CTL00, CTL00, CTL00);
    checkOutput("rr_vid_data", 32'(video_data), 32'hFF0110);
    applyStimulus(CTL00, CTL00, CTL00);
    checkOutput("rr_mix_mode", 32'(mode), 1);
    checkOutput("rr_mix_data", 32'(video_data), 32'hFF00FD);
    checkOutput("rr_mix_err", 32'(symbol_error), 32'b001);
    applyStimulus(CTL00, CTL00, CTL00);
    checkOutput("rr_end_mode", 32'(mode), 0);
    repeat (3) applyStimulus(CTL00, CTL00, CTL00);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
